// File: rtl/gb_cart_mem_if_if.sv
// CPU-side handshake and external SRAM/flash bus signals for gb_cart_mem_if.
// The slave modport is the memory interface block; the master modport is the
// CPU bus plus the external memory device.
interface gb_cart_mem_if_if;
    logic        req;
    logic        we;
    logic [15:0] addr_bus_in;
    logic [23:0] mbc_addr;
    logic        ram_enabled;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic        ack;
    logic        busy;
    logic [23:0] mem_addr;
    logic [7:0]  mem_dq_out;
    logic        mem_dq_oe;
    logic [7:0]  mem_dq_in;
    logic        mem_ce_n;
    logic        mem_oe_n;
    logic        mem_we_n;

    modport slave (
        input  req, we, addr_bus_in, mbc_addr, ram_enabled, data_in, mem_dq_in,
        output data_out, ack, busy, mem_addr, mem_dq_out, mem_dq_oe,
               mem_ce_n, mem_oe_n, mem_we_n
    );

    modport master (
        output req, we, addr_bus_in, mbc_addr, ram_enabled, data_in, mem_dq_in,
        input  data_out, ack, busy, mem_addr, mem_dq_out, mem_dq_oe,
               mem_ce_n, mem_oe_n, mem_we_n
    );
endinterface

// File: rtl/gb_cart_mem_if.sv
// Game Boy cartridge memory interface: turns each CPU cartridge access into a
// timed cycle on an external 8-bit asynchronous SRAM/flash bus. ROM reads and
// enabled RAM accesses run a full SETUP/STROBE/HOLD/DONE cycle with a
// programmable strobe width; everything else completes in one short cycle.
// MBC2 nibble RAM is emulated by forcing the upper data nibble to F.
module gb_cart_mem_if #(
    parameter int          WAIT_CYCLES = 3,
    parameter logic [23:0] RAM_BASE    = 24'h800000,
    parameter bit          NIBBLE_RAM  = 1'b1
) (
    input  logic               clock,
    input  logic               rst,
    gb_cart_mem_if_if.slave    bus
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        DONE,
        SHORT
    } state_t;

    // Strobe counter reload value; the counter runs down to zero in STROBE.
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t      state;
    state_t      next_state;
    logic [3:0]  wait_cnt;
    logic        we_q;
    logic        ram_q;
    logic [23:0] addr_q;
    logic [7:0]  dq_out_q;
    logic [7:0]  capture_q;
    logic [7:0]  data_out_q;

    logic        is_rom;
    logic        is_ram;
    logic        full_cycle;
    logic        accept;
    logic        last_strobe;
    logic        on_bus;

    // Region decode happens on the request-cycle inputs, which are exactly the
    // values latched at acceptance.
    assign is_rom      = (bus.addr_bus_in < 16'h8000);
    assign is_ram      = (bus.addr_bus_in >= 16'hA000) && (bus.addr_bus_in <= 16'hBFFF);
    assign full_cycle  = (is_rom && !bus.we) || (is_ram && bus.ram_enabled);
    assign accept      = (state == IDLE) && bus.req;
    assign last_strobe = (wait_cnt == 4'd0);
    assign on_bus      = (state == SETUP) || (state == STROBE) || (state == HOLD);

    // State register; reset aborts any access in flight without an ack.
    always_ff @(posedge clock) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic for the access sequencer.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.req) next_state = full_cycle ? SETUP : SHORT;
            SETUP:   next_state = STROBE;
            STROBE:  if (last_strobe) next_state = HOLD;
            HOLD:    next_state = DONE;
            DONE:    next_state = IDLE;
            SHORT:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Access latches, strobe counter, read capture and read data formatting.
    always_ff @(posedge clock) begin
        if (rst) begin
            wait_cnt   <= 4'd0;
            we_q       <= 1'b0;
            ram_q      <= 1'b0;
            addr_q     <= 24'd0;
            dq_out_q   <= 8'd0;
            capture_q  <= 8'd0;
            data_out_q <= 8'hFF;
        end else begin
            if (accept) begin
                we_q  <= bus.we;
                ram_q <= is_ram;
                if (full_cycle) begin
                    addr_q <= is_ram ? (RAM_BASE + bus.mbc_addr) : bus.mbc_addr;
                    if (bus.we) begin
                        dq_out_q <= (NIBBLE_RAM && is_ram) ? {4'hF, bus.data_in[3:0]}
                                                           : bus.data_in;
                    end
                end else if (!bus.we) begin
                    data_out_q <= 8'hFF;
                end
            end
            if (state == SETUP) begin
                wait_cnt <= WAIT_LOAD;
            end else if ((state == STROBE) && !last_strobe) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if ((state == STROBE) && last_strobe && !we_q) begin
                capture_q <= bus.mem_dq_in;
            end
            if ((state == HOLD) && !we_q) begin
                data_out_q <= (NIBBLE_RAM && ram_q) ? {4'hF, capture_q[3:0]} : capture_q;
            end
        end
    end

    assign bus.ack        = (state == DONE) || (state == SHORT);
    assign bus.busy       = (state != IDLE);
    assign bus.data_out   = data_out_q;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_dq_out = dq_out_q;
    assign bus.mem_dq_oe  = on_bus && we_q;
    assign bus.mem_ce_n   = !on_bus;
    assign bus.mem_oe_n   = !((state == STROBE) && !we_q);
    assign bus.mem_we_n   = !((state == STROBE) && we_q);

endmodule

// File: tb/tb_gb_cart_mem_if.sv
// Self-checking bench for gb_cart_mem_if with default parameters
// (WAIT_CYCLES=3, RAM_BASE=24'h800000, NIBBLE_RAM=1).
module tb_gb_cart_mem_if;

    logic clock;
    logic rst;

    gb_cart_mem_if_if bus();

    gb_cart_mem_if dut (
        .clock (clock),
        .rst   (rst),
        .bus   (bus)
    );

    int vectors;
    int miscompares;

    logic [7:0]  exp_q[$];
    logic [7:0]  model_dout;
    int          ce_low;
    int          oe_low;
    int          we_low;
    int          ack_cnt;
    logic [23:0] obs_addr;
    logic [7:0]  obs_dq;

    // Free-running clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Bus monitor: protocol invariants, strobe counting and scoreboard pop on ack.
    always @(negedge clock) begin
        if (!rst) begin
            vectors++;
            if ((!bus.mem_oe_n && !bus.mem_we_n) ||
                (bus.mem_ce_n && (!bus.mem_oe_n || !bus.mem_we_n)) ||
                (bus.mem_dq_oe && !bus.mem_oe_n)) begin
                miscompares++;
                $display("[TB] FAIL strobe_invariant: ce_n=%b oe_n=%b we_n=%b dq_oe=%b, required no overlap",
                         bus.mem_ce_n, bus.mem_oe_n, bus.mem_we_n, bus.mem_dq_oe);
            end
            if (!bus.mem_ce_n) begin
                ce_low++;
                obs_addr = bus.mem_addr;
            end
            if (!bus.mem_oe_n) oe_low++;
            if (!bus.mem_we_n) we_low++;
            if (bus.mem_dq_oe) obs_dq = bus.mem_dq_out;
            if (bus.ack) begin
                ack_cnt++;
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("[TB] FAIL unexpected_ack: got ack with data_out=%h, required no ack", bus.data_out);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (bus.data_out !== e) begin
                        miscompares++;
                        $display("[TB] FAIL data_out: got %h, required %h", bus.data_out, e);
                    end
                end
            end
        end
    end

    task automatic clear_counts();
        ce_low   = 0;
        oe_low   = 0;
        we_low   = 0;
        obs_addr = 24'hxxxxxx;
        obs_dq   = 8'hxx;
    endtask

    // Drive a one-cycle req pulse; called and returns on a falling edge.
    task automatic issue(input logic w, input logic [15:0] a, input logic [23:0] m,
                         input logic en, input logic [7:0] d);
        bus.we          = w;
        bus.addr_bus_in = a;
        bus.mbc_addr    = m;
        bus.ram_enabled = en;
        bus.data_in     = d;
        bus.req         = 1'b1;
        @(negedge clock);
        bus.req         = 1'b0;
    endtask

    // Count falling edges until ack, the first one being the cycle after acceptance.
    task automatic wait_ack(input int limit, output int n);
        n = 1;
        while (!bus.ack && n < limit) begin
            @(negedge clock);
            n++;
        end
        if (!bus.ack) begin
            miscompares++;
            $display("[TB] FAIL ack_timeout: got no ack within %0d cycles, required ack", limit);
        end
        #1;
    endtask

    // Push the expected read result and update the data_out model.
    task automatic expect_read(input logic [7:0] d);
        model_dout = d;
        exp_q.push_back(d);
    endtask

    task automatic expect_write();
        exp_q.push_back(model_dout);
    endtask

    task automatic check_int(input string name, input int got, input int want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    task automatic test_reset();
        rst             = 1'b1;
        bus.req         = 1'b0;
        bus.we          = 1'b0;
        bus.addr_bus_in = 16'h0000;
        bus.mbc_addr    = 24'h0;
        bus.ram_enabled = 1'b0;
        bus.data_in     = 8'h00;
        bus.mem_dq_in   = 8'h00;
        model_dout      = 8'hFF;
        repeat (3) @(negedge clock);
        vectors++;
        if ({bus.ack, bus.busy, bus.mem_ce_n, bus.mem_oe_n, bus.mem_we_n, bus.mem_dq_oe} !== 6'b001110) begin
            miscompares++;
            $display("[TB] FAIL reset_ctrl: got ack/busy/ce/oe/we/oe %b, required 001110",
                     {bus.ack, bus.busy, bus.mem_ce_n, bus.mem_oe_n, bus.mem_we_n, bus.mem_dq_oe});
        end
        vectors++;
        if ({bus.data_out, bus.mem_addr, bus.mem_dq_out} !== {8'hFF, 24'h0, 8'h00}) begin
            miscompares++;
            $display("[TB] FAIL reset_data: got dout=%h addr=%h dq=%h, required FF 000000 00",
                     bus.data_out, bus.mem_addr, bus.mem_dq_out);
        end
        rst = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_rom_read();
        int n;
        clear_counts();
        bus.mem_dq_in = 8'h5A;
        expect_read(8'h5A);
        issue(1'b0, 16'h4123, 24'h01C123, 1'b0, 8'h00);
        wait_ack(40, n);
        check_int("rom_read_latency", n, 6);
        check_int("rom_read_oe_cycles", oe_low, 3);
        check_int("rom_read_ce_cycles", ce_low, 5);
        vectors++;
        if (obs_addr !== 24'h01C123) begin
            miscompares++;
            $display("[TB] FAIL rom_read_addr: got %h, required 01c123", obs_addr);
        end
        @(negedge clock);
    endtask

    task automatic test_ram_write_read();
        int n;
        clear_counts();
        expect_write();
        issue(1'b1, 16'hA1FF, 24'h0001FF, 1'b1, 8'h37);
        wait_ack(40, n);
        check_int("ram_write_latency", n, 6);
        check_int("ram_write_we_cycles", we_low, 3);
        check_int("ram_write_oe_cycles", oe_low, 0);
        vectors++;
        if ({obs_addr, obs_dq} !== {24'h8001FF, 8'hF7}) begin
            miscompares++;
            $display("[TB] FAIL ram_write_bus: got addr=%h dq=%h, required 8001ff f7", obs_addr, obs_dq);
        end
        @(negedge clock);
        clear_counts();
        bus.mem_dq_in = 8'h07;
        expect_read(8'hF7);
        issue(1'b0, 16'hA1FF, 24'h0001FF, 1'b1, 8'h00);
        wait_ack(40, n);
        check_int("ram_read_latency", n, 6);
        check_int("ram_read_oe_cycles", oe_low, 3);
        vectors++;
        if (obs_addr !== 24'h8001FF) begin
            miscompares++;
            $display("[TB] FAIL ram_read_addr: got %h, required 8001ff", obs_addr);
        end
        @(negedge clock);
    endtask

    task automatic test_ram_disabled();
        int n;
        clear_counts();
        expect_read(8'hFF);
        issue(1'b0, 16'hA000, 24'h000000, 1'b0, 8'h00);
        wait_ack(40, n);
        check_int("ram_dis_read_latency", n, 1);
        @(negedge clock);
        expect_write();
        issue(1'b1, 16'hA000, 24'h000000, 1'b0, 8'h6C);
        wait_ack(40, n);
        check_int("ram_dis_write_latency", n, 1);
        @(negedge clock);
        check_int("ram_dis_ce_cycles", ce_low, 0);
        check_int("ram_dis_we_cycles", we_low, 0);
    endtask

    task automatic test_rom_write();
        int n;
        bus.mem_dq_in = 8'h3C;
        expect_read(8'h3C);
        issue(1'b0, 16'h0150, 24'h000150, 1'b0, 8'h00);
        wait_ack(40, n);
        @(negedge clock);
        clear_counts();
        expect_write();
        issue(1'b1, 16'h2100, 24'h002100, 1'b0, 8'h05);
        wait_ack(40, n);
        check_int("rom_write_latency", n, 1);
        @(negedge clock);
        expect_read(8'hFF);
        issue(1'b0, 16'hC000, 24'h00C000, 1'b1, 8'h00);
        wait_ack(40, n);
        check_int("noncart_read_latency", n, 1);
        @(negedge clock);
        check_int("short_ce_cycles", ce_low, 0);
    endtask

    task automatic test_req_while_busy();
        int n;
        int acks_before;
        clear_counts();
        acks_before   = ack_cnt;
        bus.mem_dq_in = 8'h99;
        expect_read(8'h99);
        issue(1'b0, 16'h7FFF, 24'h1F7FFF, 1'b0, 8'h00);
        @(negedge clock);
        @(negedge clock);
        vectors++;
        if (bus.busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL busy_in_strobe: got %b, required 1", bus.busy);
        end
        issue(1'b0, 16'h0200, 24'h000200, 1'b0, 8'h00);
        wait_ack(40, n);
        repeat (10) @(negedge clock);
        #1;
        check_int("busy_drop_acks", ack_cnt - acks_before, 1);
        check_int("busy_drop_ce_cycles", ce_low, 5);
        check_int("busy_drop_oe_cycles", oe_low, 3);
    endtask

    task automatic test_reset_mid_cycle();
        int n;
        int acks_before;
        clear_counts();
        acks_before = ack_cnt;
        issue(1'b1, 16'hA005, 24'h000005, 1'b1, 8'h4C);
        @(negedge clock);
        vectors++;
        if ({bus.mem_we_n, bus.mem_dq_oe} !== 2'b01) begin
            miscompares++;
            $display("[TB] FAIL mid_write_strobe: got we_n/dq_oe %b, required 01", {bus.mem_we_n, bus.mem_dq_oe});
        end
        rst = 1'b1;
        @(negedge clock);
        vectors++;
        if ({bus.mem_we_n, bus.mem_dq_oe, bus.mem_ce_n, bus.busy, bus.ack, bus.data_out} !== {5'b10100, 8'hFF}) begin
            miscompares++;
            $display("[TB] FAIL reset_abort: got we_n/dq_oe/ce_n/busy/ack %b dout=%h, required 10100 ff",
                     {bus.mem_we_n, bus.mem_dq_oe, bus.mem_ce_n, bus.busy, bus.ack}, bus.data_out);
        end
        model_dout = 8'hFF;
        rst = 1'b0;
        repeat (8) @(negedge clock);
        #1;
        check_int("reset_abort_acks", ack_cnt - acks_before, 0);
        @(negedge clock);
        clear_counts();
        bus.mem_dq_in = 8'hA5;
        expect_read(8'hA5);
        issue(1'b0, 16'h1234, 24'h021234, 1'b0, 8'h00);
        wait_ack(40, n);
        check_int("after_reset_latency", n, 6);
        @(negedge clock);
        clear_counts();
        acks_before     = ack_cnt;
        bus.we          = 1'b0;
        bus.addr_bus_in = 16'h0100;
        bus.mbc_addr    = 24'h000100;
        bus.req         = 1'b1;
        rst             = 1'b1;
        @(negedge clock);
        bus.req = 1'b0;
        rst     = 1'b0;
        vectors++;
        if (bus.busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL req_with_rst_busy: got %b, required 0", bus.busy);
        end
        repeat (8) @(negedge clock);
        #1;
        check_int("req_with_rst_acks", ack_cnt - acks_before, 0);
        check_int("req_with_rst_ce_cycles", ce_low, 0);
    endtask

    task automatic test_back_to_back();
        int n;
        clear_counts();
        bus.mem_dq_in = 8'h81;
        expect_read(8'hF1);
        issue(1'b0, 16'hB010, 24'hFF0010, 1'b1, 8'h00);
        wait_ack(40, n);
        check_int("b2b_first_latency", n, 6);
        vectors++;
        if (obs_addr !== 24'h7F0010) begin
            miscompares++;
            $display("[TB] FAIL ram_addr_wrap: got %h, required 7f0010", obs_addr);
        end
        @(negedge clock);
        clear_counts();
        bus.mem_dq_in = 8'hC3;
        expect_read(8'hC3);
        issue(1'b0, 16'h7000, 24'h3F7000, 1'b0, 8'h00);
        wait_ack(40, n);
        check_int("b2b_second_latency", n, 6);
        vectors++;
        if (obs_addr !== 24'h3F7000) begin
            miscompares++;
            $display("[TB] FAIL b2b_second_addr: got %h, required 3f7000", obs_addr);
        end
        @(negedge clock);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        ack_cnt     = 0;
        test_reset();
        test_rom_read();
        test_ram_write_read();
        test_ram_disabled();
        test_rom_write();
        test_req_while_busy();
        test_reset_mid_cycle();
        test_back_to_back();
        repeat (2) @(negedge clock);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL pending_acks: got %0d outstanding, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
